// File: rtl/iram_icb_arb.sv
// Shares the single iram ICB slave port among M_NUM masters with one outstanding
// transaction, routing each response back to its issuer and timing out a silent slave.
module iram_icb_arb #(
  parameter int M_NUM   = 2,
  parameter bit RR_EN   = 1'b1,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [M_NUM-1:0]    m_icb_cmd_valid,
  output logic [M_NUM-1:0]    m_icb_cmd_ready,
  input  logic [M_NUM*32-1:0] m_icb_cmd_addr,
  input  logic [M_NUM-1:0]    m_icb_cmd_read,
  input  logic [M_NUM*32-1:0] m_icb_cmd_wdata,
  input  logic [M_NUM*4-1:0]  m_icb_cmd_wmask,
  output logic [M_NUM-1:0]    m_icb_rsp_valid,
  input  logic [M_NUM-1:0]    m_icb_rsp_ready,
  output logic [M_NUM-1:0]    m_icb_rsp_err,
  output logic [M_NUM*32-1:0] m_icb_rsp_rdata,
  output logic                s_icb_cmd_valid,
  input  logic                s_icb_cmd_ready,
  output logic [31:0]         s_icb_cmd_addr,
  output logic                s_icb_cmd_read,
  output logic [31:0]         s_icb_cmd_wdata,
  output logic [3:0]          s_icb_cmd_wmask,
  input  logic                s_icb_rsp_valid,
  output logic                s_icb_rsp_ready,
  input  logic                s_icb_rsp_err,
  input  logic [31:0]         s_icb_rsp_rdata,
  output logic [1:0]          owner_o,
  output logic                busy_o
);

  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_MAX = '1;

  typedef enum logic [1:0] {IDLE, WAIT, TOUT, DRAIN} state_t;

  state_t          state;
  logic [1:0]      owner;
  logic [1:0]      last_grant;
  logic [1:0]      winner;
  logic            win_valid;
  logic            owner_rsp_ready;
  logic            wd_expired;
  logic [WD_W-1:0] wdog;
  logic [WD_W-1:0] wdog_inc;
  int              start;

  // Later loop iterations overwrite earlier ones, so the candidate closest to 'start' wins.
  always_comb begin
    winner    = '0;
    win_valid = 1'b0;
    start     = RR_EN ? int'(last_grant) + 1 : 0;
    for (int k = M_NUM - 1; k >= 0; k--) begin
      for (int i = 0; i < M_NUM; i++) begin
        if (i == (start + k) % M_NUM && m_icb_cmd_valid[i]) begin
          winner    = 2'(i);
          win_valid = 1'b1;
        end
      end
    end
  end

  always_comb begin
    owner_rsp_ready = 1'b0;
    for (int i = 0; i < M_NUM; i++) begin
      if (owner == 2'(i)) owner_rsp_ready = m_icb_rsp_ready[i];
    end
    wdog_inc   = (wdog == WD_MAX) ? wdog : wdog + WD_W'(1);
    wd_expired = (TIMEOUT != 0) && (int'(wdog) >= TIMEOUT - 1);
  end

  always_comb begin
    m_icb_cmd_ready = '0;
    m_icb_rsp_valid = '0;
    m_icb_rsp_err   = '0;
    m_icb_rsp_rdata = '0;
    s_icb_cmd_valid = 1'b0;
    s_icb_cmd_addr  = '0;
    s_icb_cmd_read  = 1'b0;
    s_icb_cmd_wdata = '0;
    s_icb_cmd_wmask = '0;
    s_icb_rsp_ready = 1'b0;
    case (state)
      IDLE: begin
        // Stray slave responses are swallowed while nothing is outstanding.
        s_icb_rsp_ready = 1'b1;
        for (int i = 0; i < M_NUM; i++) begin
          if (win_valid && winner == 2'(i)) begin
            s_icb_cmd_valid    = 1'b1;
            s_icb_cmd_addr     = m_icb_cmd_addr[i*32 +: 32];
            s_icb_cmd_read     = m_icb_cmd_read[i];
            s_icb_cmd_wdata    = m_icb_cmd_wdata[i*32 +: 32];
            s_icb_cmd_wmask    = m_icb_cmd_wmask[i*4 +: 4];
            m_icb_cmd_ready[i] = s_icb_cmd_ready;
          end
        end
      end
      WAIT: begin
        s_icb_rsp_ready = owner_rsp_ready;
        for (int i = 0; i < M_NUM; i++) begin
          if (owner == 2'(i)) begin
            m_icb_rsp_valid[i]          = s_icb_rsp_valid;
            m_icb_rsp_err[i]            = s_icb_rsp_err;
            m_icb_rsp_rdata[i*32 +: 32] = s_icb_rsp_rdata;
          end
        end
      end
      TOUT: begin
        for (int i = 0; i < M_NUM; i++) begin
          if (owner == 2'(i)) begin
            m_icb_rsp_valid[i] = 1'b1;
            m_icb_rsp_err[i]   = 1'b1;
          end
        end
      end
      DRAIN: s_icb_rsp_ready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= '0;
      last_grant <= 2'(M_NUM - 1);
      wdog       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_valid && s_icb_cmd_ready) begin
            owner      <= winner;
            last_grant <= winner;
            wdog       <= '0;
            state      <= WAIT;
          end
        end
        WAIT: begin
          // A response arriving on the expiry cycle takes precedence over the timeout.
          if (s_icb_rsp_valid) begin
            if (owner_rsp_ready) state <= IDLE;
          end else begin
            wdog <= wdog_inc;
            if (wd_expired) state <= TOUT;
          end
        end
        TOUT: begin
          if (owner_rsp_ready) begin
            wdog  <= '0;
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (s_icb_rsp_valid) begin
            state <= IDLE;
          end else begin
            wdog <= wdog_inc;
            if (wd_expired) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign owner_o = owner;
  assign busy_o  = (state != IDLE);

endmodule

// File: tb/tb_iram_icb_arb.sv
// Bench for iram_icb_arb: directed scenarios plus randomized traffic scored against
// a transaction-level arbiter/slave model through expected-command and expected-response queues.
module tb_iram_icb_arb;

  localparam int M  = 2;
  localparam int TO = 8;
  localparam logic [95:0] FP_ADDR = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000};

  typedef struct {
    int          m;
    logic [31:0] addr;
    logic        rd;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } cmd_t;

  typedef struct {
    int          m;
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;

  logic [M-1:0]    m_cmd_valid, m_cmd_read, m_rsp_ready;
  logic [M*32-1:0] m_cmd_addr, m_cmd_wdata;
  logic [M*4-1:0]  m_cmd_wmask;
  logic            s_cmd_ready, s_rsp_valid, s_rsp_err;
  logic [31:0]     s_rsp_rdata;

  logic [M-1:0]    m_cmd_ready, m_rsp_valid, m_rsp_err;
  logic [M*32-1:0] m_rsp_rdata;
  logic            s_cmd_valid, s_cmd_read, s_rsp_ready, busy;
  logic [31:0]     s_cmd_addr, s_cmd_wdata;
  logic [3:0]      s_cmd_wmask;
  logic [1:0]      owner;

  logic [2:0]  fp_valid, fp_cmd_ready, fp_rsp_valid, fp_rsp_err;
  logic        fp_s_cmd_ready, fp_s_rsp_valid;
  logic [95:0] fp_rsp_rdata;
  logic        fp_s_cmd_valid, fp_s_cmd_read, fp_s_rsp_ready, fp_busy;
  logic [31:0] fp_s_cmd_addr, fp_s_cmd_wdata;
  logic [3:0]  fp_s_cmd_wmask;
  logic [1:0]  fp_owner;

  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;
  cmd_t exp_cmd_q[$];
  rsp_t exp_rsp_q[$];
  cmd_t mon_c;
  rsp_t mon_r;

  int         lg_m;
  bit         hs_scmd, hs_srsp;
  logic [M-1:0] hs_mcmd;
  int         gap[M];
  bit         slv_active, slv_never, nx_never;
  int         slv_lat, slv_cnt, nx_lat;
  logic [31:0] slv_data, nx_data;
  logic       slv_err, nx_err;

  iram_icb_arb #(.M_NUM(M), .RR_EN(1'b1), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m_icb_cmd_valid(m_cmd_valid), .m_icb_cmd_ready(m_cmd_ready),
    .m_icb_cmd_addr(m_cmd_addr), .m_icb_cmd_read(m_cmd_read),
    .m_icb_cmd_wdata(m_cmd_wdata), .m_icb_cmd_wmask(m_cmd_wmask),
    .m_icb_rsp_valid(m_rsp_valid), .m_icb_rsp_ready(m_rsp_ready),
    .m_icb_rsp_err(m_rsp_err), .m_icb_rsp_rdata(m_rsp_rdata),
    .s_icb_cmd_valid(s_cmd_valid), .s_icb_cmd_ready(s_cmd_ready),
    .s_icb_cmd_addr(s_cmd_addr), .s_icb_cmd_read(s_cmd_read),
    .s_icb_cmd_wdata(s_cmd_wdata), .s_icb_cmd_wmask(s_cmd_wmask),
    .s_icb_rsp_valid(s_rsp_valid), .s_icb_rsp_ready(s_rsp_ready),
    .s_icb_rsp_err(s_rsp_err), .s_icb_rsp_rdata(s_rsp_rdata),
    .owner_o(owner), .busy_o(busy)
  );

  iram_icb_arb #(.M_NUM(3), .RR_EN(1'b0), .TIMEOUT(0)) u_fp (
    .clk(clk), .rst(rst),
    .m_icb_cmd_valid(fp_valid), .m_icb_cmd_ready(fp_cmd_ready),
    .m_icb_cmd_addr(FP_ADDR), .m_icb_cmd_read(3'b000),
    .m_icb_cmd_wdata(96'd0), .m_icb_cmd_wmask(12'd0),
    .m_icb_rsp_valid(fp_rsp_valid), .m_icb_rsp_ready(3'b111),
    .m_icb_rsp_err(fp_rsp_err), .m_icb_rsp_rdata(fp_rsp_rdata),
    .s_icb_cmd_valid(fp_s_cmd_valid), .s_icb_cmd_ready(fp_s_cmd_ready),
    .s_icb_cmd_addr(fp_s_cmd_addr), .s_icb_cmd_read(fp_s_cmd_read),
    .s_icb_cmd_wdata(fp_s_cmd_wdata), .s_icb_cmd_wmask(fp_s_cmd_wmask),
    .s_icb_rsp_valid(fp_s_rsp_valid), .s_icb_rsp_ready(fp_s_rsp_ready),
    .s_icb_rsp_err(1'b0), .s_icb_rsp_rdata(32'd0),
    .owner_o(fp_owner), .busy_o(fp_busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic resetModel();
    exp_cmd_q.delete();
    exp_rsp_q.delete();
    lg_m       = M - 1;
    hs_scmd    = 1'b0;
    hs_srsp    = 1'b0;
    hs_mcmd    = '0;
    slv_active = 1'b0;
    for (int i = 0; i < M; i++) gap[i] = 0;
  endtask

  task automatic newCmd(input int i);
    m_cmd_valid[i]        = 1'b1;
    m_cmd_read[i]         = 1'($urandom_range(0, 1));
    m_cmd_addr[i*32 +: 32]  = $urandom;
    m_cmd_wdata[i*32 +: 32] = $urandom;
    m_cmd_wmask[i*4 +: 4]   = 4'($urandom_range(0, 15));
  endtask

  // Reference: round-robin winner from the masters' own request state, and the
  // response the master must see given how long the slave stays silent.
  task automatic modelGrant();
    int   w;
    int   mode;
    cmd_t c;
    rsp_t r;
    w = -1;
    for (int k = 1; k <= M; k++) begin
      int idx;
      idx = (lg_m + k) % M;
      if (w < 0 && m_cmd_valid[idx]) w = idx;
    end
    c.m = w;
    c.addr = '0; c.rd = 1'b0; c.wdata = '0; c.wmask = '0;
    if (w >= 0) begin
      c.addr  = m_cmd_addr[w*32 +: 32];
      c.rd    = m_cmd_read[w];
      c.wdata = m_cmd_wdata[w*32 +: 32];
      c.wmask = m_cmd_wmask[w*4 +: 4];
      lg_m    = w;
    end
    exp_cmd_q.push_back(c);
    mode     = $urandom_range(0, 9);
    nx_data  = $urandom;
    nx_err   = ($urandom_range(0, 3) == 0);
    nx_never = (mode == 9);
    if (mode < 7)
      nx_lat = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TO - 1) : $urandom_range(0, 2);
    else
      nx_lat = $urandom_range(TO, 2 * TO - 1);
    r.m = w;
    if (mode < 7) begin
      r.err   = nx_err;
      r.rdata = nx_data;
    end else begin
      r.err   = 1'b1;
      r.rdata = '0;
    end
    exp_rsp_q.push_back(r);
  endtask

  task automatic applyStimulus(input int n, input bit issue);
    repeat (n) begin
      @(negedge clk);
      for (int i = 0; i < M; i++) begin
        if (hs_mcmd[i]) begin
          m_cmd_valid[i] = 1'b0;
          gap[i] = $urandom_range(0, 3);
        end else if (m_cmd_valid[i] && $urandom_range(0, 15) == 0) begin
          m_cmd_valid[i] = 1'b0;
          gap[i] = 1;
        end
        if (!m_cmd_valid[i]) begin
          if (gap[i] > 0) gap[i]--;
          else if (issue) newCmd(i);
        end
        m_rsp_ready[i] = ($urandom_range(0, 3) != 0);
      end
      s_cmd_ready = ($urandom_range(0, 3) != 0);
      if (hs_srsp) begin
        s_rsp_valid = 1'b0;
        slv_active  = 1'b0;
      end
      if (hs_scmd) begin
        slv_active = 1'b1;
        slv_cnt    = 0;
        slv_lat    = nx_lat;
        slv_never  = nx_never;
        slv_data   = nx_data;
        slv_err    = nx_err;
      end else if (slv_active) begin
        slv_cnt++;
      end
      if (slv_active && !slv_never && !s_rsp_valid && slv_cnt >= slv_lat) begin
        s_rsp_valid = 1'b1;
        s_rsp_rdata = slv_data;
        s_rsp_err   = slv_err;
      end
      if (!s_rsp_valid) begin
        s_rsp_rdata = $urandom;
        s_rsp_err   = 1'($urandom_range(0, 1));
      end
      #2;
      hs_scmd = s_cmd_valid && s_cmd_ready;
      hs_srsp = s_rsp_valid && s_rsp_ready;
      hs_mcmd = m_cmd_valid & m_cmd_ready;
      if (hs_scmd) modelGrant();
    end
  endtask

  // Monitor: pops an expectation whenever a handshake is visible on either side.
  always @(negedge clk) begin
    #3;
    if (mon_en && !rst) begin
      if (s_cmd_valid && s_cmd_ready) begin
        if (exp_cmd_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL cmd_unexpected actual=grant expected=none at %0t", $time);
        end else begin
          mon_c = exp_cmd_q.pop_front();
          checkOutput("cmd_grant", 64'(m_cmd_ready), (mon_c.m >= 0) ? (64'(1) << mon_c.m) : 64'(0));
          checkOutput("cmd_addr", 64'(s_cmd_addr), 64'(mon_c.addr));
          checkOutput("cmd_read", 64'(s_cmd_read), 64'(mon_c.rd));
          checkOutput("cmd_wdata", 64'(s_cmd_wdata), 64'(mon_c.wdata));
          checkOutput("cmd_wmask", 64'(s_cmd_wmask), 64'(mon_c.wmask));
        end
      end
      for (int i = 0; i < M; i++) begin
        if (m_rsp_valid[i] && m_rsp_ready[i]) begin
          if (exp_rsp_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL rsp_unexpected actual=lane%0d expected=none at %0t", i, $time);
          end else begin
            mon_r = exp_rsp_q.pop_front();
            checkOutput("rsp_lane", 64'(i), 64'(mon_r.m));
            checkOutput("rsp_err", 64'(m_rsp_err[i]), 64'(mon_r.err));
            checkOutput("rsp_rdata", 64'(m_rsp_rdata[i*32 +: 32]), 64'(mon_r.rdata));
            checkOutput("rsp_owner", 64'(owner), 64'(mon_r.m));
          end
        end
      end
      checkOutput("rsp_single_lane", 64'($countones(m_rsp_valid) <= 1), 64'(1));
    end
  end

  initial begin
    rst = 1'b1;
    m_cmd_valid = '0; m_cmd_read = '0; m_rsp_ready = '0;
    m_cmd_addr = '0; m_cmd_wdata = '0; m_cmd_wmask = '0;
    s_cmd_ready = 1'b0; s_rsp_valid = 1'b0; s_rsp_err = 1'b0; s_rsp_rdata = '0;
    fp_valid = '0; fp_s_cmd_ready = 1'b0; fp_s_rsp_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_busy", 64'(busy), 64'(0));
    checkOutput("rst_owner", 64'(owner), 64'(0));
    checkOutput("rst_cmd_ready", 64'(m_cmd_ready), 64'(0));
    checkOutput("rst_rsp_valid", 64'(m_rsp_valid), 64'(0));
    checkOutput("rst_s_cmd_valid", 64'(s_cmd_valid), 64'(0));
    checkOutput("rst_s_rsp_ready", 64'(s_rsp_ready), 64'(1));
    checkOutput("rst_rsp_rdata", 64'(m_rsp_rdata), 64'(0));

    // M0 read answered after one cycle
    @(negedge clk);
    rst = 1'b0;
    m_cmd_valid = 2'b01; m_cmd_read = 2'b01; m_cmd_addr[31:0] = 32'h0000_0010;
    s_cmd_ready = 1'b1; m_rsp_ready = 2'b11;
    #1;
    checkOutput("rd_s_cmd_valid", 64'(s_cmd_valid), 64'(1));
    checkOutput("rd_s_cmd_addr", 64'(s_cmd_addr), 64'h10);
    checkOutput("rd_cmd_ready", 64'(m_cmd_ready), 64'(2'b01));
    checkOutput("rd_busy_before", 64'(busy), 64'(0));
    @(negedge clk);
    m_cmd_valid = '0; s_cmd_ready = 1'b0;
    s_rsp_valid = 1'b1; s_rsp_rdata = 32'hDEAD_BEEF; s_rsp_err = 1'b0;
    #1;
    checkOutput("rd_busy_wait", 64'(busy), 64'(1));
    checkOutput("rd_rsp_valid", 64'(m_rsp_valid), 64'(2'b01));
    checkOutput("rd_rsp_rdata", 64'(m_rsp_rdata[31:0]), 64'hDEAD_BEEF);
    checkOutput("rd_rsp_lane1_rdata", 64'(m_rsp_rdata[63:32]), 64'(0));
    @(negedge clk);
    s_rsp_valid = 1'b0;
    #1;
    checkOutput("rd_busy_after", 64'(busy), 64'(0));

    // M1 write with M0 pending behind a held-off response
    @(negedge clk);
    m_cmd_valid = 2'b10; m_cmd_read = 2'b00;
    m_cmd_addr[63:32] = 32'h0000_0100; m_cmd_wdata[63:32] = 32'hA5A5_A5A5; m_cmd_wmask[7:4] = 4'b0011;
    s_cmd_ready = 1'b0;
    #1;
    checkOutput("wr_s_cmd_addr", 64'(s_cmd_addr), 64'h100);
    checkOutput("wr_s_cmd_read", 64'(s_cmd_read), 64'(0));
    checkOutput("wr_s_cmd_wdata", 64'(s_cmd_wdata), 64'hA5A5_A5A5);
    checkOutput("wr_s_cmd_wmask", 64'(s_cmd_wmask), 64'(4'b0011));
    checkOutput("wr_cmd_ready_stall", 64'(m_cmd_ready), 64'(0));
    @(negedge clk);
    s_cmd_ready = 1'b1;
    #1;
    checkOutput("wr_cmd_ready", 64'(m_cmd_ready), 64'(2'b10));
    @(negedge clk);
    m_cmd_valid = 2'b01; s_rsp_valid = 1'b1; s_rsp_rdata = 32'h1111_2222; m_rsp_ready = 2'b00;
    repeat (5) begin
      #1;
      checkOutput("hold_s_rsp_ready", 64'(s_rsp_ready), 64'(0));
      checkOutput("hold_rsp_valid", 64'(m_rsp_valid), 64'(2'b10));
      checkOutput("hold_no_grant", 64'({s_cmd_valid, m_cmd_ready}), 64'(0));
      @(negedge clk);
    end
    m_rsp_ready = 2'b10;
    #1;
    checkOutput("hold_owner", 64'(owner), 64'(1));
    @(negedge clk);
    s_rsp_valid = 1'b0;
    #1;
    checkOutput("after_hold_grant_m0", 64'(m_cmd_ready), 64'(2'b01));
    @(negedge clk);
    m_cmd_valid = '0; s_cmd_ready = 1'b0;
    s_rsp_valid = 1'b1; m_rsp_ready = 2'b01;
    @(negedge clk);
    s_rsp_valid = 1'b0;

    // Fixed-priority instance: after granting master 0, lowest index still wins
    fp_valid = 3'b001; fp_s_cmd_ready = 1'b1;
    @(negedge clk);
    fp_valid = '0; fp_s_cmd_ready = 1'b0; fp_s_rsp_valid = 1'b1;
    @(negedge clk);
    fp_s_rsp_valid = 1'b0; fp_valid = 3'b101;
    #1;
    checkOutput("fp_101", 64'(fp_s_cmd_addr), 64'h1000);
    fp_valid = 3'b110;
    #1;
    checkOutput("fp_110", 64'(fp_s_cmd_addr), 64'h2000);
    fp_valid = 3'b100;
    #1;
    checkOutput("fp_100", 64'(fp_s_cmd_addr), 64'h3000);
    fp_valid = 3'b011; fp_s_cmd_ready = 1'b1;
    #1;
    checkOutput("fp_ready_011", 64'(fp_cmd_ready), 64'(3'b001));
    @(negedge clk);
    fp_valid = '0; fp_s_cmd_ready = 1'b0;

    // Randomized traffic against the model
    rst = 1'b1;
    m_cmd_valid = '0; s_rsp_valid = 1'b0; s_cmd_ready = 1'b0;
    resetModel();
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    applyStimulus(3000, 1'b1);
    applyStimulus(200, 1'b0);
    mon_en = 1'b0;
    checkOutput("cmd_queue_empty", 64'(exp_cmd_q.size()), 64'(0));
    checkOutput("rsp_queue_empty", 64'(exp_rsp_q.size()), 64'(0));
    checkOutput("end_busy", 64'(busy), 64'(0));

    // Reset during WAIT abandons the transaction
    @(negedge clk);
    m_cmd_valid = 2'b10; m_cmd_read = 2'b10; m_cmd_addr[63:32] = 32'h20;
    s_cmd_ready = 1'b1; s_rsp_valid = 1'b0; m_rsp_ready = 2'b11;
    @(negedge clk);
    m_cmd_valid = '0; s_cmd_ready = 1'b0;
    #1;
    checkOutput("rstw_busy_before", 64'(busy), 64'(1));
    checkOutput("rstw_owner_before", 64'(owner), 64'(1));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; s_rsp_valid = 1'b1; s_rsp_rdata = 32'h1234_5678;
    #1;
    checkOutput("rstw_busy", 64'(busy), 64'(0));
    checkOutput("rstw_owner", 64'(owner), 64'(0));
    checkOutput("rstw_rsp_valid", 64'(m_rsp_valid), 64'(0));
    checkOutput("rstw_s_rsp_ready", 64'(s_rsp_ready), 64'(1));
    @(negedge clk);
    s_rsp_valid = 1'b0;
    #1;
    checkOutput("rstw_rsp_valid_late", 64'(m_rsp_valid), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
